inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 11 +
 rtl/inst_fetch_queue_if.sv | 32 +++
 rtl/inst_fetch_queue.sv | 78 +++++++
 tb/tb_inst_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch-queue sizing and entry layout
package ifq_define;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch/decode side signals of the instruction queue
interface inst_fetch_queue_if;
  import ifq_define::*;

  logic             flush;
  logic             in_valid_1;
  logic             in_valid_2;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst_1;
  logic [31:0]      in_inst_2;
  logic             fetch_stall;
  logic             out_valid_1;
  logic             out_valid_2;
  logic [31:0]      out_pc_1;
  logic [31:0]      out_inst_1;
  logic [31:0]      out_pc_2;
  logic [31:0]      out_inst_2;
  logic [1:0]       pop_cnt;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid_1, in_valid_2, in_pc, in_inst_1, in_inst_2, pop_cnt,
    input  fetch_stall, out_valid_1, out_valid_2, out_pc_1, out_inst_1,
           out_pc_2, out_inst_2, count
  );

  modport slave (
    input  flush, in_valid_1, in_valid_2, in_pc, in_inst_1, in_inst_2, pop_cnt,
    output fetch_stall, out_valid_1, out_valid_2, out_pc_1, out_inst_1,
           out_pc_2, out_inst_2, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - dual-issue circular instruction queue, FWFT read ports
module inst_fetch_queue
  import ifq_define::*;
#(
  parameter int DEPTH = ifq_define::DEPTH,
  parameter int PTR_W = ifq_define::PTR_W
) (
  input  logic               clk,
  input  logic               resetn,
  inst_fetch_queue_if.slave  ifq
);

  localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(DEPTH - 2);

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_stall;
  logic [1:0]       w_push;
  logic [1:0]       w_pop_req;
  logic [1:0]       w_pop;
  logic [PTR_W-1:0] w_tail_p1;
  logic [PTR_W-1:0] w_head_p1;
  logic             w_valid_1;
  logic             w_valid_2;

  // Stall is deliberately conservative: a two-wide push must always fit.
  assign w_stall   = (r_count > STALL_LVL) || ifq.flush;
  assign w_tail_p1 = r_tail + PTR_W'(1);
  assign w_head_p1 = r_head + PTR_W'(1);

  always_comb begin
    w_push = 2'd0;
    if (!w_stall && ifq.in_valid_1)
      w_push = ifq.in_valid_2 ? 2'd2 : 2'd1;
  end

  always_comb begin
    w_pop_req = (ifq.pop_cnt == 2'd3) ? 2'd2 : ifq.pop_cnt;
    w_pop     = w_pop_req;
    if ({{(PTR_W-1){1'b0}}, w_pop_req} > r_count)
      w_pop = r_count[1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn || ifq.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_push);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_push != 2'd0)
      r_mem[r_tail] <= '{pc: ifq.in_pc, inst: ifq.in_inst_1};
    if (resetn && w_push == 2'd2)
      r_mem[w_tail_p1] <= '{pc: ifq.in_pc + 32'd4, inst: ifq.in_inst_2};
  end

  assign w_valid_1 = (r_count != '0);
  assign w_valid_2 = (r_count >= (PTR_W+1)'(2));

  assign ifq.fetch_stall = w_stall;
  assign ifq.count       = r_count;
  assign ifq.out_valid_1 = w_valid_1;
  assign ifq.out_valid_2 = w_valid_2;
  assign ifq.out_pc_1    = w_valid_1 ? r_mem[r_head].pc      : 32'd0;
  assign ifq.out_inst_1  = w_valid_1 ? r_mem[r_head].inst    : 32'd0;
  assign ifq.out_pc_2    = w_valid_2 ? r_mem[w_head_p1].pc   : 32'd0;
  assign ifq.out_inst_2  = w_valid_2 ? r_mem[w_head_p1].inst : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  inst_fetch_queue_if ifq ();

  inst_fetch_queue dut (
    .clk    (clk),
    .resetn (resetn),
    .ifq    (ifq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifq.flush      = 1'b0;
    ifq.in_valid_1 = 1'b0;
    ifq.in_valid_2 = 1'b0;
    ifq.in_pc      = 32'd0;
    ifq.in_inst_1  = 32'd0;
    ifq.in_inst_2  = 32'd0;
    ifq.pop_cnt    = 2'd0;
  endtask

  task automatic push(input logic [31:0] pc, input bit two, input logic [1:0] pop);
    ifq.in_valid_1 = 1'b1;
    ifq.in_valid_2 = two;
    ifq.in_pc      = pc;
    ifq.in_inst_1  = pc ^ 32'hA5A5_A5A5;
    ifq.in_inst_2  = (pc + 32'd4) ^ 32'hA5A5_A5A5;
    ifq.pop_cnt    = pop;
  endtask

  initial begin
    logic [31:0] next_pc;
    logic [31:0] exp_pop;
    int          mcount;
    int          amt;
    int          pushed;
    int          popped;

    errors = 0;
    checks = 0;
    resetn = 1'b0;
    idle();
    step();
    step();
    resetn = 1'b1;
    #1;

    chk("reset_count",  32'(ifq.count),       32'd0);
    chk("reset_ov1",    32'(ifq.out_valid_1), 32'd0);
    chk("reset_ov2",    32'(ifq.out_valid_2), 32'd0);
    chk("reset_pc1",    ifq.out_pc_1,         32'd0);
    chk("reset_inst2",  ifq.out_inst_2,       32'd0);
    chk("reset_stall",  32'(ifq.fetch_stall), 32'd0);

    // First dual push at the boot vector.
    push(32'h1FC0_0000, 1'b1, 2'd0);
    step();
    idle();
    #1;
    chk("boot_count", 32'(ifq.count),       32'd2);
    chk("boot_pc1",   ifq.out_pc_1,         32'h1FC0_0000);
    chk("boot_pc2",   ifq.out_pc_2,         32'h1FC0_0004);
    chk("boot_ov1",   32'(ifq.out_valid_1), 32'd1);
    chk("boot_ov2",   32'(ifq.out_valid_2), 32'd1);
    chk("boot_inst1", ifq.out_inst_1,       32'h1FC0_0000 ^ 32'hA5A5_A5A5);

    // Fill to 7, then a dropped two-push, then pop two.
    push(32'h1FC0_0008, 1'b1, 2'd0);
    step();
    push(32'h1FC0_0010, 1'b1, 2'd0);
    step();
    idle();
    #1;
    chk("fill6_count", 32'(ifq.count),       32'd6);
    chk("fill6_stall", 32'(ifq.fetch_stall), 32'd0);
    push(32'h1FC0_0018, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("fill7_count", 32'(ifq.count),       32'd7);
    chk("fill7_stall", 32'(ifq.fetch_stall), 32'd1);
    push(32'h0000_0100, 1'b1, 2'd0);
    step();
    idle();
    #1;
    chk("drop_count", 32'(ifq.count), 32'd7);
    chk("drop_pc1",   ifq.out_pc_1,   32'h1FC0_0000);
    ifq.pop_cnt = 2'd2;
    step();
    idle();
    #1;
    chk("pop2_count", 32'(ifq.count),       32'd5);
    chk("pop2_stall", 32'(ifq.fetch_stall), 32'd0);
    chk("pop2_pc1",   ifq.out_pc_1,         32'h1FC0_0008);
    chk("pop2_pc2",   ifq.out_pc_2,         32'h1FC0_000C);

    // One-cycle reset with count=5.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    chk("rst5_count", 32'(ifq.count),       32'd0);
    chk("rst5_ov1",   32'(ifq.out_valid_1), 32'd0);
    chk("rst5_pc1",   ifq.out_pc_1,         32'd0);

    // Over-pop clamped by occupancy while a single push lands.
    push(32'h0000_0200, 1'b0, 2'd0);
    step();
    push(32'h0000_0300, 1'b0, 2'd2);
    step();
    idle();
    #1;
    chk("pp_count", 32'(ifq.count),       32'd1);
    chk("pp_inst1", ifq.out_inst_1,       32'h0000_0300 ^ 32'hA5A5_A5A5);
    chk("pp_pc1",   ifq.out_pc_1,         32'h0000_0300);
    chk("pp_ov2",   32'(ifq.out_valid_2), 32'd0);
    chk("pp_pc2",   ifq.out_pc_2,         32'd0);

    // Fill to 6, then flush against a push and a pop.
    push(32'h0000_0400, 1'b1, 2'd0);
    step();
    push(32'h0000_0500, 1'b1, 2'd0);
    step();
    push(32'h0000_0600, 1'b0, 2'd0);
    step();
    idle();
    #1;
    chk("pre_flush_count", 32'(ifq.count), 32'd6);
    push(32'h0000_0700, 1'b1, 2'd2);
    ifq.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(ifq.fetch_stall), 32'd1);
    step();
    idle();
    #1;
    chk("flush_count", 32'(ifq.count),       32'd0);
    chk("flush_ov1",   32'(ifq.out_valid_1), 32'd0);
    chk("flush_ov2",   32'(ifq.out_valid_2), 32'd0);
    chk("flush_pc1",   ifq.out_pc_1,         32'd0);
    chk("flush_inst1", ifq.out_inst_1,       32'd0);
    chk("flush_pc2",   ifq.out_pc_2,         32'd0);
    chk("flush_inst2", ifq.out_inst_2,       32'd0);

    // pop_cnt=3 on empty, then on two entries.
    ifq.pop_cnt = 2'd3;
    step();
    idle();
    #1;
    chk("pop3_empty", 32'(ifq.count), 32'd0);
    push(32'h0000_0800, 1'b1, 2'd0);
    step();
    idle();
    ifq.pop_cnt = 2'd3;
    step();
    idle();
    #1;
    chk("pop3_two", 32'(ifq.count), 32'd0);

    // Alternating 1/2 pushes with single pops across the index wrap.
    next_pc = 32'h0000_1000;
    exp_pop = 32'h0000_1000;
    mcount  = 0;
    for (int i = 0; i < 20; i++) begin
      amt = (i % 2 == 0) ? 1 : 2;
      push(next_pc, amt == 2, 2'd1);
      #1;
      chk("wrap_stall", 32'(ifq.fetch_stall), (mcount > 6) ? 32'd1 : 32'd0);
      popped = 0;
      if (mcount >= 1) begin
        chk("wrap_pop_pc",   ifq.out_pc_1,   exp_pop);
        chk("wrap_pop_inst", ifq.out_inst_1, exp_pop ^ 32'hA5A5_A5A5);
        exp_pop = exp_pop + 32'd4;
        popped  = 1;
      end
      pushed = (mcount > 6) ? 0 : amt;
      next_pc = next_pc + 32'(4 * pushed);
      mcount  = mcount + pushed - popped;
      step();
      chk("wrap_count", 32'(ifq.count), 32'(mcount));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
